// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues reads to a 1-cycle imem, buffers {instr, pc+4}.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response arriving into an empty queue straight to the output.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          AW       = 7,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [31:0]   flush_pc,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic [31:0]   out_pc4
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          pending_q, pending_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   pc4_q   [DEPTH];

   logic          issue;
   logic          resp_valid;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [31:0]   pend_pc4;
   logic [CW:0]   occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign imem_addr  = fetch_pc_q[AW+1:2];
   assign pend_pc4   = pend_pc_q + 32'd4;
   assign fifo_empty = (count_q == '0);
   assign resp_valid = pending_q && !flush;

   // Pops are not credited here, so an outstanding read always has a free slot waiting for it.
   assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
   assign issue      = !flush && (occupancy < (CW+1)'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass_hit;

   assign bypass_hit = fifo_empty && resp_valid;
   assign out_valid  = !fifo_empty || bypass_hit;
   assign out_instr  = fifo_empty ? imem_rdata : instr_q[rd_ptr_q];
   assign out_pc4    = fifo_empty ? pend_pc4   : pc4_q[rd_ptr_q];
   assign push       = resp_valid && !(bypass_hit && out_ready);
   assign pop        = !fifo_empty && out_ready && !flush;
`else
   assign out_valid  = !fifo_empty;
   assign out_instr  = instr_q[rd_ptr_q];
   assign out_pc4    = pc4_q[rd_ptr_q];
   assign push       = resp_valid;
   assign pop        = !fifo_empty && out_ready && !flush;
`endif

   // Flush wins over issue/push/pop; the in-flight response is simply forgotten via pending.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pending_d  = issue;
      pend_pc_d  = pend_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (flush) begin
         fetch_pc_d = flush_pc & ~32'd3;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_pc_d  = fetch_pc_q;
         end
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         pending_q  <= 1'b0;
         pend_pc_q  <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pending_q  <= pending_d;
         pend_pc_q  <= pend_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr_q] <= imem_rdata;
         pc4_q[wr_ptr_q]   <= pend_pc4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized flush/stall run against a PC scoreboard.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          AW       = 7;
   localparam logic [31:0] RESET_PC = 32'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [31:0]   flush_pc = 32'd0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata = 32'd0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc4;

   int            vectors = 0;
   int            miscompares = 0;
   int            delivered = 0;
   logic [63:0]   sb_q[$];
   logic [31:0]   next_pc = RESET_PC;
   logic          stalled_prev = 1'b0;
   logic [31:0]   held_instr = 32'd0;
   logic [31:0]   held_pc4 = 32'd0;
   logic [63:0]   exp_entry;

   fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc4   (out_pc4)
   );

   always #5 clk = ~clk;

   // Registered-output instruction memory: word i holds 0x1000_0000 + i.
   always @(posedge clk) imem_rdata <= 32'h1000_0000 + {25'd0, imem_addr};

   function automatic logic [31:0] wordAt(input logic [31:0] pc);
      return 32'h1000_0000 + {25'd0, pc[AW+1:2]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic refill();
      while (sb_q.size() < 8) begin
         sb_q.push_back({wordAt(next_pc), next_pc + 32'd4});
         next_pc = next_pc + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] pc);
      sb_q.delete();
      next_pc = pc & ~32'd3;
      refill();
   endtask

   // One cycle: drive inputs after the falling edge, then check what the DUT shows for this cycle.
   task automatic applyStimulus(input logic r, input logic f, input logic [31:0] fpc, input logic rdy);
      @(negedge clk);
      rst = r;
      flush = f;
      flush_pc = fpc;
      out_ready = rdy;
      #1;
      if (stalled_prev) begin
         checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("stall_instr", out_instr, held_instr);
         checkOutput("stall_pc4", out_pc4, held_pc4);
      end
      if (!r && !f && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
         end else begin
            exp_entry = sb_q.pop_front();
            checkOutput("sb_instr", out_instr, exp_entry[63:32]);
            checkOutput("sb_pc4", out_pc4, exp_entry[31:0]);
            refill();
         end
         delivered++;
      end
      stalled_prev = !r && !f && out_valid && !out_ready;
      held_instr = out_instr;
      held_pc4 = out_pc4;
      if (r) restart(RESET_PC);
      else if (f) restart(fpc);
   endtask

   task automatic doReset(input logic rdy);
      repeat (2) applyStimulus(1'b1, 1'b0, 32'd0, rdy);
   endtask

   initial begin
      restart(RESET_PC);

      // Streaming after reset: first valid at LAT, then one word per cycle.
      doReset(1'b1);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
         if (k == 0) checkOutput("rst_addr", {25'd0, imem_addr}, 32'd0);
         checkOutput($sformatf("a_valid_%0d", k), {31'd0, out_valid}, (k >= LAT) ? 32'd1 : 32'd0);
      end

      // Stall: queue fills to DEPTH, address stops at word 4, then drains 0..7 in order.
      doReset(1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
         if (k >= 5) checkOutput($sformatf("b_addr_%0d", k), {25'd0, imem_addr}, 32'd4);
      end
      checkOutput("b_valid", {31'd0, out_valid}, 32'd1);
      delivered = 0;
      for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("b_delivered", {31'd0, delivered >= 8}, 32'd1);

      // Flush to 0x43 with 3 entries queued and a read in flight.
      doReset(1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0043, 1'b0);
      for (int j = 1; j <= 6; j++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
         if (j == 1) checkOutput("c_addr", {25'd0, imem_addr}, 32'h10);
         checkOutput($sformatf("c_valid_%0d", j), {31'd0, out_valid}, (j >= LAT + 1) ? 32'd1 : 32'd0);
      end

      // Flush coinciding with a pop and an arriving response; then reset together with flush.
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("d_valid_pre", {31'd0, out_valid}, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("d_valid_post", {31'd0, out_valid}, 32'd0);
      checkOutput("d_addr_post", {25'd0, imem_addr}, 32'h40);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("d_rst_addr", {25'd0, imem_addr}, {25'd0, RESET_PC[AW+1:2]});
      checkOutput("d_rst_valid", {31'd0, out_valid}, 32'd0);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

      // PC wrap at the top of the address space.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int j = 1; j <= 6; j++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
         if (j == LAT + 1) begin
            checkOutput("e_pc4_wrap", out_pc4, 32'h0000_0000);
            checkOutput("e_instr_wrap", out_instr, 32'h1000_007F);
         end
         if (j == LAT + 2) begin
            checkOutput("e_pc4_next", out_pc4, 32'h0000_0004);
            checkOutput("e_instr_next", out_instr, 32'h1000_0000);
         end
      end

      // Random back-pressure with random flushes and the odd reset.
      delivered = 0;
      for (int k = 0; k < 1000; k++) begin
         applyStimulus(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                       $urandom,
                       $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
      end
      checkOutput("f_progress", {31'd0, delivered >= 100}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch buffer between the instruction memory and the decode stage of the five-stage CPU. It owns the fetch PC, drives word addresses into the registered-output instruction memory (1-cycle read latency), and buffers returned words with their PC+4 in a small FIFO. Decode consumes entries through a valid/ready handshake. A flush, driven by the MEM-stage branch resolution, redirects fetch and discards everything buffered or in flight.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; legal 2..16
- AW, 7, instruction-memory word-address width (imem_addr = pc[AW+1:2])
- RESET_PC, 32'd0, fetch PC after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  redirect fetch; discard queue and in-flight read
- flush_pc  in  32  new fetch PC, valid when flush=1; bits [1:0] ignored (treated as 0)
- imem_addr  out  AW  word address to instruction memory
- imem_rdata  in  32  instruction word, valid the cycle after its address was presented
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head entry
- out_instr  out  32  head instruction
- out_pc4  out  32  head entry PC + 4

## Operation
- State: fetch_pc[31:0], pending (1 bit, a read was issued last cycle), pend_pc[31:0], FIFO of DEPTH x {instr, pc4}, count.
- imem_addr = fetch_pc[AW+1:2] every cycle, combinationally from the register.
- Issue condition: issue = !flush && (count + pending < DEPTH). Pops in the same cycle are not credited.
- On issue: pending<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit, wraps modulo 2^32). Otherwise: pending<=0, fetch_pc holds. The memory still reads the held address; that data is ignored because pending=0.
- Response: if pending=1 and no flush, {imem_rdata, pend_pc+4} is pushed. Guaranteed non-full by the issue rule.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Flush (highest priority, same cycle as any push/pop/issue): count<=0, pending<=0, fetch_pc<={flush_pc[31:2],2'b00}. No issue in the flush cycle. The response arriving that cycle is dropped, and a pop presented that cycle is ignored.
- out_instr/out_pc4 are don't-care when out_valid=0. They must not change while out_valid=1 && out_ready=0 unless flush is asserted.
- Reset: fetch_pc=RESET_PC, pending=0, count=0, out_valid=0, imem_addr=RESET_PC[AW+1:2]. Reset asserted mid-operation discards all contents identically, and reset dominates flush.

## Timing
- Without bypass: address presented in cycle N (issue), data arrives N+1 (push), out_valid in N+2. After rst drops at cycle 0: first out_valid at cycle 2, out_pc4=RESET_PC+4.
- Sustained throughput of 1 instr/cycle with out_ready held at 1 requires DEPTH>=3 (non-bypass) or DEPTH>=2 (bypass).
- Flush in cycle F: first address from flush_pc presented in F+1, first valid output F+3 (F+2 with bypass).
- Stall: with out_ready=0, issue stops once count+pending=DEPTH, and no entry is lost or overwritten.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0 and a valid response arrives (no flush), it drives out_valid/out_instr/out_pc4 combinationally that cycle. If popped the same cycle it is not written to the FIFO; otherwise it is pushed. Load-to-use latency is 1 cycle.
- Not defined: outputs come from FIFO storage only. Outputs are registered-state driven and latency is 2 cycles.

## Test plan
- Reset, out_ready=1, memory word i = 0x1000_0000+i: out_valid first at cycle 2 (1 with bypass), then consecutive words 0x10000000, 0x10000001, ... with out_pc4 4, 8, 12, ..., one per cycle, no gaps.
- out_ready=0 for 10 cycles after reset, DEPTH=4: count saturates at 4 and imem_addr stops advancing at word 4. Releasing out_ready yields words 0..7 in order with none duplicated or missing.
- Flush with flush_pc=0x0000_0043 while 3 entries are queued and a read is in flight: queue empties and imem_addr=0x10 next cycle. The next delivered out_pc4=0x44 with the instruction from word 0x10, and no pre-flush word ever appears.
- Simultaneous flush, pop, and arriving response in one cycle: out_valid=0 next cycle and count=0. Assert rst at the same time: fetch_pc=RESET_PC, with reset taking precedence over flush_pc.
- fetch_pc=0xFFFF_FFFC via flush: that word is followed by word 0 with out_pc4=0x0000_0000 for the first entry and 0x4 for the next (32-bit wrap).
- Random out_ready (50%) for 1000 cycles with random flushes: scoreboard delivered {instr, pc4} against the PC sequence reconstructed from the flush history. Check zero loss and zero reorder, and that out_instr is stable while stalled.
